// File: rtl/seq_div8.sv
// rtl/seq_div8.sv - multi-cycle unsigned restoring divider with start/busy/done handshake
module seq_div8 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             DBZ
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_b;
    logic [CW-1:0]    r_cnt;

    logic [WIDTH:0]   w_rem_shift;
    logic [WIDTH:0]   w_trial;
    logic             w_borrow;
    logic [WIDTH-1:0] w_rem_next;
    logic [WIDTH-1:0] w_q_next;
    logic             w_last;

    // A borrow out of the trial subtraction means the divisor did not fit: restore.
    assign w_rem_shift = {r_rem, r_q[WIDTH-1]};
    assign w_trial     = w_rem_shift - {1'b0, r_b};
    assign w_borrow    = w_trial[WIDTH];
    assign w_rem_next  = w_borrow ? w_rem_shift[WIDTH-1:0] : w_trial[WIDTH-1:0];
    assign w_q_next    = {r_q[WIDTH-2:0], ~w_borrow};
    assign w_last      = (r_cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = (B != '0) ? S_RUN : S_DONE;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                done         = 1'b1;
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Q/R/DBZ are only touched on acceptance or completion so they hold through IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rem <= '0;
            r_q   <= '0;
            r_b   <= '0;
            r_cnt <= '0;
            Q     <= '0;
            R     <= '0;
            DBZ   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (B != '0) begin
                            r_b   <= B;
                            r_q   <= A;
                            r_rem <= '0;
                            r_cnt <= '0;
                            DBZ   <= 1'b0;
                        end else begin
                            DBZ <= 1'b1;
                            Q   <= '1;
                            R   <= A;
                        end
                    end
                end
                S_RUN: begin
                    r_rem <= w_rem_next;
                    r_q   <= w_q_next;
                    r_cnt <= r_cnt + CW'(1);
                    if (w_last) begin
                        Q <= w_q_next;
                        R <= w_rem_next;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
